// File: rtl/pc_pkg.sv
// Shared CPU constants for the accumulator CPU: address width and reset vector.
package pc_pkg;

    localparam int unsigned CPU_ADDR_W     = 5;
    localparam int unsigned CPU_RESET_ADDR = 0;

    typedef logic [CPU_ADDR_W-1:0] cpu_addr_t;

endpackage : pc_pkg

// File: rtl/pc.sv
// Program counter: increments every cycle or loads a jump target; async active-high reset.
module pc
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CPU_RESET_ADDR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jmp_en_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Jump beats increment; the increment wraps modulo 2^ADDR_W.
    always_comb begin
        pc_d = pc_q + ADDR_W'(1);
        if (jmp_en_i) begin
            pc_d = jmp_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign addr_o = pc_q;

endmodule : pc

// File: tb/tb_pc.sv
// Directed testbench for pc: vector table plus hand-written async-reset sequences.
module tb_pc;

    localparam int unsigned AW = 5;

    logic          clk_i;
    logic          rst_i;
    logic          jmp_en_i;
    logic [AW-1:0] jmp_addr_i;
    logic [AW-1:0] addr_o;

    int n_checks;
    int n_fail;

    typedef struct {
        logic          rst;
        logic          jmp_en;
        logic [AW-1:0] jmp_addr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    pc dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .jmp_en_i   (jmp_en_i),
        .jmp_addr_i (jmp_addr_i),
        .addr_o     (addr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: addr_o=%0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic j, input int unsigned a, input int unsigned e);
        vec_t v;
        v.rst      = r;
        v.jmp_en   = j;
        v.jmp_addr = AW'(a);
        v.exp_addr = AW'(e);
        return v;
    endfunction

    // One rising edge with inputs applied on the preceding falling edge.
    task automatic step(input logic r, input logic j, input logic [AW-1:0] a);
        @(negedge clk_i);
        rst_i      = r;
        jmp_en_i   = j;
        jmp_addr_i = a;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_i      = 1'b0;
        jmp_en_i   = 1'b0;
        jmp_addr_i = '0;

        // Reset takes effect before any clock edge.
        #2 rst_i = 1'b1;
        #1 check("reset_immediate", addr_o, AW'(0));

        vecs.push_back(mk(1, 0,  0,  0));   // held in reset
        vecs.push_back(mk(1, 0,  0,  0));
        vecs.push_back(mk(1, 1, 25,  0));   // reset beats jump
        vecs.push_back(mk(0, 0,  0,  1));   // release: first edge increments
        vecs.push_back(mk(0, 0,  0,  2));
        vecs.push_back(mk(0, 0,  0,  3));
        vecs.push_back(mk(0, 1, 25, 25));   // jump
        vecs.push_back(mk(0, 1, 25, 25));   // sustained jump holds target
        vecs.push_back(mk(0, 1, 25, 25));
        vecs.push_back(mk(0, 0,  0, 26));
        vecs.push_back(mk(0, 0,  0, 27));
        vecs.push_back(mk(0, 1, 31, 31));
        vecs.push_back(mk(0, 0,  0,  0));   // wrap 31 -> 0
        vecs.push_back(mk(0, 0,  0,  1));
        vecs.push_back(mk(1, 1, 25,  0));
        vecs.push_back(mk(0, 1, 25, 25));   // release with jump still high
        vecs.push_back(mk(0, 0,  0, 26));
        vecs.push_back(mk(1, 0,  0,  0));
        vecs.push_back(mk(0, 0,  0,  1));   // release with jump low
        vecs.push_back(mk(0, 1,  0,  0));   // jump to address 0
        vecs.push_back(mk(0, 1,  7,  7));
        vecs.push_back(mk(0, 0, 19,  8));   // jmp_addr ignored without enable
        vecs.push_back(mk(0, 1, 30, 30));
        vecs.push_back(mk(0, 0,  0, 31));
        vecs.push_back(mk(0, 0,  0,  0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].jmp_en, vecs[i].jmp_addr);
            check($sformatf("vec%0d", i), addr_o, vecs[i].exp_addr);
        end

        // X on jmp_en while reset is high has no effect.
        step(1'b1, 1'bx, AW'(25));
        check("reset_x_jmp_en", addr_o, AW'(0));

        // Async reset mid-run: count to 5, then assert between edges.
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, '0);
            check($sformatf("count%0d", k), addr_o, AW'(k));
        end
        #2 rst_i = 1'b1;
        #1 check("async_mid_cycle", addr_o, AW'(0));
        step(1'b1, 1'b0, '0);
        check("async_hold", addr_o, AW'(0));
        for (int k = 1; k <= 2; k++) begin
            step(1'b0, 1'b0, '0);
            check($sformatf("recount%0d", k), addr_o, AW'(k));
        end

        // Async reset with a jump pending clears without waiting for the edge.
        @(negedge clk_i);
        jmp_en_i   = 1'b1;
        jmp_addr_i = AW'(25);
        #1 rst_i = 1'b1;
        #1 check("async_jump_pending", addr_o, AW'(0));
        @(posedge clk_i);
        #1 check("async_jump_pending_edge", addr_o, AW'(0));
        step(1'b0, 1'b1, AW'(25));
        check("release_jump", addr_o, AW'(25));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc

// File: doc/pc.md
Name: pc

Overview:
- 5-bit program counter for the simple accumulator CPU. Presents the current instruction address to instruction memory.
- Each cycle it either increments by one or loads a jump target from the control unit.
- Purely sequential register with next-address logic. No handshaking.

Parameters:
- ADDR_W, 5, width of the address register and of the jump address; memory spans 2^ADDR_W words.
- RESET_ADDR, 0, value loaded on reset (ADDR_W bits wide).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset; forces addr_o to RESET_ADDR.
- jmp_en_i  input  1  jump enable; when high, the next edge loads jmp_addr_i.
- jmp_addr_i  input  ADDR_W  jump target address.
- addr_o  output  ADDR_W  current PC value, driven directly from the register.

Interface rules:
- One clock (clk_i).
- Reset rst_i is asynchronous and active-high. Polarity and synchronicity are fixed.

Behaviour:
- State: a single ADDR_W-bit register, pc_q; addr_o = pc_q with no combinational path from the inputs.
- Reset:
  - On rst_i rising, pc_q becomes RESET_ADDR (0) immediately, without waiting for a clock edge.
  - While rst_i is high, pc_q holds RESET_ADDR regardless of the clock, jmp_en_i or jmp_addr_i.
- Release: after rst_i falls, the first rising clk_i edge performs a normal update.
- Update priority at each rising edge with rst_i low:
  1. jmp_en_i = 1: pc_q <= jmp_addr_i.
  2. otherwise: pc_q <= pc_q + 1.
- Latency: one cycle. A jump or increment is visible on addr_o right after the edge that samples it.
- Sustained jump: if jmp_en_i stays high, pc_q reloads jmp_addr_i every cycle, i.e. holds the target. No increment occurs past the target until jmp_en_i drops.
- Wrap-around: increment is modulo 2^ADDR_W; 31 + 1 = 0 with the default width. There is no carry or overflow flag.
- Simultaneous events: reset beats jump, and jump beats increment.
- Reset asserted mid-cycle clears pc_q asynchronously, even if a jump is pending.
- Inputs are sampled only at the rising edge. X on jmp_en_i while rst_i is high has no effect.
- Power-up without reset is undefined. The system is required to apply rst_i before use.

Decomposition:
- Shared CPU package/header holds:
  - ADDR_W (5), shared with memory and control.
  - RESET_ADDR (0).
- No sub-module needed. The next-address mux may be a local combinational block inside pc.

Test Plan:
- Reset: hold rst_i = 1 for 2+ cycles with jmp_en_i = 0 -> addr_o = 0 throughout, including immediately on assertion before any edge.
- Increment: release rst_i, run N edges -> addr_o = 1, 2, ... N, one step per rising edge.
- Jump: with addr_o anywhere, set jmp_en_i = 1, jmp_addr_i = 5'b11001 -> addr_o = 25 after the next edge. Keeping jmp_en_i high holds 25. Dropping it gives 26, 27, ...
- Wrap-around: jump to 31, then drop jmp_en_i -> next edge addr_o = 0, then 1.
- Priority: assert rst_i and jmp_en_i = 1, jmp_addr_i = 25 together -> addr_o = 0 and stays 0. Release rst_i -> first edge loads 25 if jmp_en_i is still high, else 1.
- Async reset mid-run: counting at e.g. 5, raise rst_i between clock edges -> addr_o = 0 immediately. After release it counts 1, 2, ...
